// File: rtl/register_file_nr_mw_if.sv
// ---------------------------------------------------------------------------
// register_file_nr_mw_if
//   Bus bundle for the multiport latch register file.
//   raddr : NUM_RPORTS read addresses          (master -> slave)
//   rdata : NUM_RPORTS read data words         (slave  -> master)
//   waddr : NUM_WPORTS write addresses         (master -> slave)
//   wdata : NUM_WPORTS write data words        (master -> slave)
//   we    : NUM_WPORTS write enables           (master -> slave)
//   be    : NUM_WPORTS byte-enable vectors     (master -> slave)
// ---------------------------------------------------------------------------
interface register_file_nr_mw_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_RPORTS = 3,
   parameter int unsigned NUM_WPORTS = 2
);
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr;
   logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata;
   logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr;
   logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata;
   logic [NUM_WPORTS-1:0]                 we;
   logic [NUM_WPORTS-1:0][NUM_BYTES-1:0]  be;

   modport master (output raddr, waddr, wdata, we, be, input  rdata);
   modport slave  (input  raddr, waddr, wdata, we, be, output rdata);
endinterface

// File: rtl/register_file_nr_mw.sv
// ---------------------------------------------------------------------------
// register_file_nr_mw
//   Latch-based register file with NUM_RPORTS combinational read ports and
//   NUM_WPORTS byte-enabled write ports. Writes are sampled into flops at the
//   rising edge ending the request cycle and land in the latch array during
//   the following high phase. When ports collide on a byte the highest port
//   index wins; disjoint bytes from different ports merge. With ZERO_REG set,
//   word 0 is a constant zero with no storage.
//
//   clk       : clock
//   rst_n     : asynchronous active-low reset (flops and gate enables only)
//   test_en_i : forces every clock gate open
//   bus       : slave side of register_file_nr_mw_if (raddr/rdata,
//               waddr/wdata/we/be)
// ---------------------------------------------------------------------------
module register_file_nr_mw #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_RPORTS = 3,
   parameter int unsigned NUM_WPORTS = 2,
   parameter bit          ZERO_REG   = 1'b0
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  test_en_i,
   register_file_nr_mw_if.slave bus
);

   localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam int unsigned SEL_WIDTH = (NUM_WPORTS > 1) ? $clog2(NUM_WPORTS) : 1;

   typedef logic [SEL_WIDTH-1:0] sel_t;

   logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_q;
   logic [NUM_WPORTS-1:0][NUM_BYTES-1:0]  be_q;
   logic [DATA_WIDTH-1:0]                 mem [NUM_WORDS];

   logic global_en;
   logic global_en_q;
   logic clk_global;

   // Per-port sampling stage; a port's flops only move when it writes.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         for (int p = 0; p < NUM_WPORTS; p++) begin
            if (bus.we[p]) begin
               wdata_q[p] <= bus.wdata[p];
               be_q[p]    <= bus.be[p];
            end
         end
      end
   end

   // Global gate: any write request (or DFT) opens the shared gated clock.
   assign global_en = (|bus.we) | test_en_i;

   // NOTE: the gate enable is held in a latch that is transparent only while
   // clk is low, so the enable is frozen for the whole high phase and the
   // gated clock cannot glitch.
   always_latch begin
      if (!clk) global_en_q <= global_en;
   end

   assign clk_global = clk & global_en_q;

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      if (ZERO_REG && (w == 0)) begin : g_zero
         assign mem[w] = '0;
      end else begin : g_latch
         logic [NUM_BYTES-1:0]                hit_d;
         logic [NUM_BYTES-1:0]                hit_q;
         logic [NUM_BYTES-1:0][SEL_WIDTH-1:0] sel_d;
         logic [NUM_BYTES-1:0][SEL_WIDTH-1:0] sel_q;
         logic                                word_en;
         logic                                word_en_q;
         logic                                clk_word;
         logic [DATA_WIDTH-1:0]               word_q;

         // Which bytes of this word are written this cycle, and by whom.
         // NOTE: every variable gets a default before the loop; a path that
         // leaves one unassigned would infer a latch.
         always_comb begin
            hit_d = '0;
            sel_d = '0;
            // NOTE: ports are scanned in ascending order, so the last match,
            // i.e. the highest port index, is the one that sticks.
            for (int p = 0; p < NUM_WPORTS; p++) begin
               if (bus.we[p] && (bus.waddr[p] == ADDR_WIDTH'(w))) begin
                  for (int b = 0; b < NUM_BYTES; b++) begin
                     if (bus.be[p][b]) begin
                        hit_d[b] = 1'b1;
                        sel_d[b] = sel_t'(p);
                     end
                  end
               end
            end
         end

         // hit_q marks the bytes of this word written last cycle; sel_q keeps
         // the winning port so the latch picks the right sampled lane.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hit_q <= '0;
               sel_q <= '0;
            end else begin
               hit_q <= hit_d;
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (hit_d[b]) sel_q[b] <= sel_d[b];
               end
            end
         end

         // Reset dominates test mode so an in-flight write never lands.
         assign word_en = rst_n & ((|hit_d) | test_en_i);

         always_latch begin
            if (!clk) word_en_q <= word_en;
         end

         assign clk_word = clk_global & word_en_q;

         // NOTE: the storage latches carry no reset; contents are undefined
         // until written, which keeps each bit a plain latch.
         always_latch begin
            if (clk_word) begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  // hit_q ties the byte to this word; the winner's sampled
                  // enable confirms the lane it is taking data from.
                  if (hit_q[b] && be_q[sel_q[b]][b]) begin
                     word_q[b*8 +: 8] <= wdata_q[sel_q[b]][b*8 +: 8];
                  end
               end
            end
         end

         assign mem[w] = word_q;
      end
   end

   // Combinational read ports, no bypass of in-flight writes.
   always_comb begin
      bus.rdata = '0;
      for (int r = 0; r < NUM_RPORTS; r++) begin
         bus.rdata[r] = mem[bus.raddr[r]];
      end
   end

endmodule
